// File: rtl/param_stream_mux.sv
// param_stream_mux: N-to-1 stream mux with direct or round-robin selection and a registered output slot
module param_stream_mux #(
  parameter int NUM_IN = 31,
  parameter int DATA_W = 2,
  parameter int SEL_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               err_cnt
);
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_sel, r_rr_ptr;
  logic              r_out_valid;
  logic [7:0]        r_err_cnt;
  logic [SEL_W-1:0]  w_lo, w_hi, w_gnt;
  logic              w_hi_any, w_sel_ok, w_gnt_vld, w_slot_free, w_xfer;
  // w_hi: first valid at/after the pointer; w_lo: first valid overall, used when the search wraps
  always_comb begin
    w_lo = '0;
    w_hi = '0;
    w_hi_any = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--)
      if (in_valid[i]) begin
        w_lo = SEL_W'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_hi = SEL_W'(i);
          w_hi_any = 1'b1;
        end
      end
  end
  assign w_sel_ok    = 32'(sel) < NUM_IN;
  assign w_gnt_vld   = mode ? |in_valid : (w_sel_ok && in_valid[sel]);
  assign w_gnt       = mode ? (w_hi_any ? w_hi : w_lo) : sel;
  assign w_slot_free = ~r_out_valid | out_ready;
  assign w_xfer      = w_gnt_vld & w_slot_free & ~rst;
  assign in_ready    = w_xfer ? (NUM_IN'(1) << w_gnt) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_rr_ptr    <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data[int'(w_gnt)*DATA_W +: DATA_W];
        r_out_sel   <= w_gnt;
      end else if (out_ready) r_out_valid <= 1'b0;
      if (w_xfer && mode) r_rr_ptr <= (int'(w_gnt) == NUM_IN - 1) ? '0 : w_gnt + 1'b1;
      if (!mode && !w_sel_ok && w_slot_free && r_err_cnt != 8'hff) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;
  assign err_cnt   = r_err_cnt;
endmodule
